keyvalue_req_queue: RTL and testbench

KEYVALUE_REQ_QUEUE -- requirements
Module: keyvalue_req_queue

---
 rtl/keyvalue_req_queue.sv | 157 +++++++++++++++
 tb/tb_keyvalue_req_queue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyvalue_req_queue.sv
// Command FIFO and single-outstanding bus requester for a key-value core.
// Ports: cmd_* in, STB/CYC/WE/ADR/DAT/flags out, ACK/DAT/DUP in, rsp_* out.
module keyvalue_req_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_1,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic        cmd_adr_is_key,
  input  logic        cmd_dat_is_key,
  input  logic [15:0] cmd_adr,
  input  logic [15:0] cmd_dat,
  output logic        STB_o,
  output logic        CYC_o,
  output logic        WE_o,
  output logic        ADR_IS_KEY_o,
  output logic        DAT_IS_KEY_o,
  output logic [15:0] ADR_o,
  output logic [15:0] DAT_o,
  input  logic        ACK_i,
  input  logic [15:0] DAT_i,
  input  logic        DUP_i,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_dat,
  output logic        rsp_dup,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 35;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   wait_cnt;

  logic push;
  logic pop;
  logic ack;
  logic tmo;
  logic rsp_take;

  assign cmd_ready = (count < CNT_FULL);
  assign push      = cmd_valid && cmd_ready;
  // Issue only when the response slot is free, so at most
  // one request/response is ever in flight.
  assign pop       = (state == IDLE) && (count != '0)
                     && !rsp_valid;
  assign ack       = (state == REQ) && ACK_i;
  // ACK wins over the timeout threshold in the same cycle.
  assign tmo       = (state == REQ) && !ACK_i
                     && (wait_cnt == WAIT_LAST);
  assign rsp_take  = rsp_valid && rsp_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || (count != '0);

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_we, cmd_adr_is_key,
                      cmd_dat_is_key, cmd_adr, cmd_dat};
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst_1) begin
    if (sys_rst_1) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst_1) begin
    if (sys_rst_1) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pop) state_nxt = REQ;
      REQ:     if (ack || tmo) state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst_1) begin
    if (sys_rst_1) begin
      STB_o        <= 1'b0;
      CYC_o        <= 1'b0;
      WE_o         <= 1'b0;
      ADR_IS_KEY_o <= 1'b0;
      DAT_IS_KEY_o <= 1'b0;
      ADR_o        <= '0;
      DAT_o        <= '0;
      wait_cnt     <= '0;
      rsp_valid    <= 1'b0;
      rsp_dat      <= '0;
      rsp_dup      <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      if (pop) begin
        {WE_o, ADR_IS_KEY_o, DAT_IS_KEY_o,
         ADR_o, DAT_o} <= head;
        STB_o    <= 1'b1;
        CYC_o    <= 1'b1;
        wait_cnt <= '0;
      end else if (ack) begin
        STB_o       <= 1'b0;
        CYC_o       <= 1'b0;
        wait_cnt    <= '0;
        rsp_valid   <= 1'b1;
        rsp_dat     <= DAT_i;
        rsp_dup     <= DUP_i;
        rsp_timeout <= 1'b0;
      end else if (tmo) begin
        STB_o       <= 1'b0;
        CYC_o       <= 1'b0;
        wait_cnt    <= '0;
        rsp_valid   <= 1'b1;
        rsp_dat     <= '0;
        rsp_dup     <= 1'b0;
        rsp_timeout <= 1'b1;
      end else if (state == REQ) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (rsp_take) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keyvalue_req_queue.sv
// Scoreboard bench for keyvalue_req_queue: random commands, a core
// model with chosen ACK latency, and a decoupled response monitor.
module tb_keyvalue_req_queue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic        cmd_adr_is_key = 1'b0;
  logic        cmd_dat_is_key = 1'b0;
  logic [15:0] cmd_adr = '0;
  logic [15:0] cmd_dat = '0;
  logic        STB_o, CYC_o, WE_o;
  logic        ADR_IS_KEY_o, DAT_IS_KEY_o;
  logic [15:0] ADR_o, DAT_o;
  logic        ACK_i = 1'b0;
  logic [15:0] DAT_i = '0;
  logic        DUP_i = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_dat;
  logic        rsp_dup, rsp_timeout, busy;

  keyvalue_req_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(clk), .sys_rst_1(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr_is_key(cmd_adr_is_key),
    .cmd_dat_is_key(cmd_dat_is_key),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .STB_o(STB_o), .CYC_o(CYC_o), .WE_o(WE_o),
    .ADR_IS_KEY_o(ADR_IS_KEY_o), .DAT_IS_KEY_o(DAT_IS_KEY_o),
    .ADR_o(ADR_o), .DAT_o(DAT_o),
    .ACK_i(ACK_i), .DAT_i(DAT_i), .DUP_i(DUP_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat(rsp_dat), .rsp_dup(rsp_dup),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // commands accepted but not yet issued, in order
  logic [34:0] cmd_q[$];
  // expected responses {dat, dup, timeout}
  logic [17:0] exp_q[$];
  int pushed = 0;
  int issued = 0;

  bit          hold_rsp = 1'b0;
  bit          f_use = 1'b0;
  int          f_lat = 0;
  logic [15:0] f_dat = '0;
  logic        f_dup = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // core model state
  bit          trk = 1'b0;
  int          cnt = 0;
  int          lat = 0;
  int          exp_dur = 0;
  logic [15:0] c_dat;
  logic        c_dup;
  logic [34:0] c_bus;

  always @(negedge clk) begin
    ACK_i = 1'b0;
    DAT_i = 16'($urandom);
    DUP_i = 1'($urandom);
    if (rst) begin
      trk = 1'b0;
    end else begin
      if (trk && !STB_o) begin
        chk("stb_cycles", 64'(cnt), 64'(exp_dur));
        trk = 1'b0;
      end
      if (STB_o) begin
        chk("cyc_eq_stb", CYC_o, 1'b1);
        if (!trk) begin
          trk = 1'b1;
          cnt = 0;
          issued++;
          chk("issue_rsp_clear", rsp_valid, 1'b0);
          c_bus = {WE_o, ADR_IS_KEY_o, DAT_IS_KEY_o, ADR_o, DAT_o};
          if (cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_no_cmd actual=%0h expected=none",
                     c_bus);
          end else begin
            chk("issue_cmd", c_bus, cmd_q.pop_front());
          end
          lat   = f_use ? f_lat : $urandom_range(1, TIMEOUT + 3);
          c_dat = f_use ? f_dat : 16'($urandom);
          c_dup = f_use ? f_dup : 1'($urandom);
          if (lat > TIMEOUT) begin
            exp_dur = TIMEOUT;
            exp_q.push_back({16'h0, 1'b0, 1'b1});
          end else begin
            exp_dur = lat;
          end
        end else begin
          chk("bus_stable",
              {WE_o, ADR_IS_KEY_o, DAT_IS_KEY_o, ADR_o, DAT_o}, c_bus);
        end
        cnt++;
        if (cnt == lat) begin
          ACK_i = 1'b1;
          DAT_i = c_dat;
          DUP_i = c_dup;
          exp_q.push_back({c_dat, c_dup, 1'b0});
        end
      end else if ($urandom_range(0, 3) == 0) begin
        // stray ACK with no strobe must not produce anything
        ACK_i = 1'b1;
      end
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (rst) begin
      rsp_ready = 1'b0;
    end else begin
      rsp_ready = !hold_rsp && ($urandom_range(0, 3) != 0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual=%0h expected=none",
                   {rsp_dat, rsp_dup, rsp_timeout});
        end else begin
          chk("rsp", {rsp_dat, rsp_dup, rsp_timeout}, exp_q[0]);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive_cycle(input bit v, input logic [34:0] c);
    @(negedge clk);
    #1;
    chk("cmd_ready", cmd_ready, ((pushed - issued) < DEPTH));
    cmd_valid = v;
    {cmd_we, cmd_adr_is_key, cmd_dat_is_key, cmd_adr, cmd_dat} = c;
    if (v && cmd_ready) begin
      cmd_q.push_back(c);
      pushed++;
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    do begin
      drive_cycle(1'b0, '0);
      n++;
    end while ((busy || rsp_valid) && n < 300);
    chk({nm, "_idle"}, {busy, rsp_valid}, 2'b00);
    chk({nm, "_cmdq"}, 64'(cmd_q.size()), 0);
    chk({nm, "_expq"}, 64'(exp_q.size()), 0);
  endtask

  function automatic logic [34:0] rnd_cmd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[34:0];
  endfunction

  logic [57:0] all_out;
  assign all_out = {STB_o, CYC_o, WE_o, ADR_IS_KEY_o, DAT_IS_KEY_o,
                    ADR_o, DAT_o, rsp_valid, rsp_dat, rsp_dup,
                    rsp_timeout, busy};

  initial begin
    @(negedge clk);
    #1;
    chk("reset_outputs", all_out, '0);
    rst = 1'b0;
    drive_cycle(1'b0, '0);
    chk("ready_after_rst", cmd_ready, 1'b1);

    // read: issue latency and 3-cycle ACK
    f_use = 1'b1;
    f_lat = 3;
    f_dat = 16'hBEEF;
    f_dup = 1'b0;
    drive_cycle(1'b1, {3'b000, 16'h0012, 16'h0000});
    drive_cycle(1'b0, '0);
    chk("lat_n1_stb", STB_o, 1'b0);
    drive_cycle(1'b0, '0);
    chk("lat_n2_stb", STB_o, 1'b1);
    drain("read");

    // timeout: no ACK
    f_lat = 100;
    drive_cycle(1'b1, {3'b000, 16'h0034, 16'h5555});
    drain("timeout");

    // ACK on the timeout threshold cycle
    f_lat = TIMEOUT;
    f_dat = 16'h1234;
    drive_cycle(1'b1, {3'b001, 16'h0056, 16'h0000});
    drain("race");

    // duplicate-key write
    f_lat = 2;
    f_dat = 16'h0F0F;
    f_dup = 1'b1;
    drive_cycle(1'b1, {3'b110, 16'h0078, 16'h00AA});
    drain("dup");

    // full FIFO with response held
    f_use = 1'b0;
    hold_rsp = 1'b1;
    repeat (5) drive_cycle(1'b1, rnd_cmd());
    chk("full_pushed", 64'(pushed - issued), 64'(DEPTH));
    repeat (20) begin
      drive_cycle(1'b1, rnd_cmd());
      chk("full_ready", cmd_ready, 1'b0);
    end
    chk("full_one_issued", 64'(cmd_q.size()), 64'(DEPTH));
    hold_rsp = 1'b0;
    drain("full");

    // random traffic
    repeat (400) drive_cycle($urandom_range(0, 1) == 1, rnd_cmd());
    drain("random");

    // reset while a request is outstanding with two queued
    f_use = 1'b1;
    f_lat = 100;
    repeat (3) drive_cycle(1'b1, rnd_cmd());
    drive_cycle(1'b0, '0);
    drive_cycle(1'b0, '0);
    chk("pre_rst_stb", STB_o, 1'b1);
    chk("pre_rst_queued", 64'(cmd_q.size()), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", all_out, '0);
    cmd_q.delete();
    exp_q.delete();
    pushed = 0;
    issued = 0;
    repeat (3) begin
      drive_cycle(1'b0, '0);
      chk("in_rst_rsp", rsp_valid, 1'b0);
    end
    rst = 1'b0;
    repeat (12) begin
      drive_cycle(1'b0, '0);
      chk("post_rst_quiet", {busy, STB_o, rsp_valid}, 3'b000);
    end
    chk("post_rst_ready", cmd_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule
